// File: rtl/imem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter_pkg
// Purpose  : Shared processor package. Holds the default word and address
//            widths used by the single-cycle core and the instruction-memory
//            arbiter state encoding.
// Contents : DEF_DATA_WIDTH, DEF_ADDR_WIDTH, DEF_MAX_WAIT, arb_state_e
// Revision : 1.0 - initial release
// ============================================================================
package imem_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_MAX_WAIT   = 4;

  // FETCH_PRI : fetch port has priority, loader wins only after starving.
  // LOAD_LOCK : loader owns the memory for a locked burst.
  typedef enum logic [0:0] {
    FETCH_PRI = 1'b0,
    LOAD_LOCK = 1'b1
  } arb_state_e;

endpackage : imem_arbiter_pkg
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter
// Purpose  : Arbitrates a single-ported synchronous instruction memory between
//            the core fetch port (read) and a program loader (write).
//            Fetch has priority; a starving loader is forced through after
//            MAX_WAIT denied cycles, and a locked loader burst excludes fetch.
// Ports    : clk, rst_n            clock, asynchronous active-low reset
//            f_req/f_addr          fetch request and byte address
//            f_gnt/f_rvalid/f_rdata fetch grant, 1-cycle read response
//            l_req/l_lock/l_addr/l_wdata  loader write request, burst lock
//            l_gnt                 loader grant
//            mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
// Revision : 1.0 - initial release
// ============================================================================
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  input  logic                  l_req,
  input  logic                  l_lock,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  arb_state_e              state_q,      state_d;
  logic [WAIT_W-1:0]       wait_cnt_q,   wait_cnt_d;
  logic                    f_rvalid_q,   f_rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_hold_q, rdata_hold_d;
  logic                    lock_active;

  // Byte-offset bits of both addresses are intentionally ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{f_addr[1:0], l_addr[1:0]};

  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;

    // A locked burst only continues while l_lock stays high; the first cycle
    // it drops is already arbitrated with fetch priority.
    lock_active = (state_q == LOAD_LOCK) && l_lock;

    // Grants are forced low while reset is asserted, even though they are
    // otherwise purely combinational from the requests.
    if (rst_n) begin
      if (lock_active) begin
        l_gnt = l_req;
      end else if (f_req && l_req) begin
        if (wait_cnt_q == MAX_WAIT_C) begin
          l_gnt = 1'b1;
        end else begin
          f_gnt = 1'b1;
        end
      end else begin
        f_gnt = f_req;
        l_gnt = l_req;
      end
    end

    if (lock_active || (l_gnt && l_lock)) begin
      state_d = LOAD_LOCK;
    end else begin
      state_d = FETCH_PRI;
    end

    if (l_gnt || !l_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    f_rvalid_d   = f_gnt;
    // Capture the returned word so f_rdata holds it once f_rvalid drops.
    rdata_hold_d = f_rvalid_q ? mem_rdata : rdata_hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH_PRI;
      wait_cnt_q   <= '0;
      f_rvalid_q   <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      f_rvalid_q   <= f_rvalid_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  assign f_rvalid  = f_rvalid_q;
  // The memory read is synchronous, so the word is on mem_rdata in the
  // response cycle itself; outside it the captured copy is shown.
  assign f_rdata   = f_rvalid_q ? mem_rdata : rdata_hold_q;

  assign mem_en    = f_gnt | l_gnt;
  assign mem_we    = l_gnt;
  assign mem_addr  = l_gnt ? l_addr[ADDR_WIDTH-1:2] :
                     f_gnt ? f_addr[ADDR_WIDTH-1:2] : '0;
  assign mem_wdata = l_gnt ? l_wdata : '0;

endmodule : imem_arbiter
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_arbiter
// Purpose  : Self-checking bench for imem_arbiter with a small synchronous
//            memory model. Directed steps push expected per-cycle grant/memory
//            outputs and expected fetch data into queues; a monitor pops and
//            compares on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

  typedef struct packed {
    logic        f_gnt;
    logic        l_gnt;
    logic        en;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        l_req = 1'b0;
  logic        l_lock = 1'b0;
  logic [31:0] l_addr = '0;
  logic [31:0] l_wdata = '0;
  logic        l_gnt;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  cyc_t        cyc_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] last_rd = '0;

  logic [31:0] mem     [0:63];
  logic        written [0:63];

  imem_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MAX_WAIT  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .l_req    (l_req),
    .l_lock   (l_lock),
    .l_addr   (l_addr),
    .l_wdata  (l_wdata),
    .l_gnt    (l_gnt),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory; unwritten words read as 0xA000_0000 | index.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) written[i] <= 1'b0;
    end else if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr[5:0]]     <= mem_wdata;
        written[mem_addr[5:0]] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr[5:0]] ? mem[mem_addr[5:0]]
                                            : (32'hA000_0000 | {26'd0, mem_addr[5:0]});
      end
    end
  end

  task automatic step(input logic rst, input logic fr, input logic [31:0] fa,
                      input logic lr, input logic ll, input logic [31:0] la,
                      input logic [31:0] lw, input logic ef, input logic el,
                      input logic prd, input logic [31:0] erd);
    cyc_t e;
    @(posedge clk);
    #1;
    rst_n   = rst;
    f_req   = fr;
    f_addr  = fa;
    l_req   = lr;
    l_lock  = ll;
    l_addr  = la;
    l_wdata = lw;
    e.f_gnt = ef;
    e.l_gnt = el;
    e.en    = ef | el;
    e.we    = el;
    e.addr  = el ? la[31:2] : (ef ? fa[31:2] : 30'd0);
    e.wdata = el ? lw : 32'd0;
    cyc_q.push_back(e);
    if (prd) rd_q.push_back(erd);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: per-cycle outputs and fetch responses.
  initial begin
    cyc_t e;
    cyc_t act;
    logic [31:0] erd;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        e   = cyc_q.pop_front();
        act = {f_gnt, l_gnt, mem_en, mem_we, mem_addr, mem_wdata};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, act, e);
        end
      end
      if (!rst_n) last_rd = '0;
      checks++;
      if (f_rvalid === 1'b1) begin
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid t=%0t: got f_rvalid=1 f_rdata=%h expected f_rvalid=0",
                   $time, f_rdata);
        end else begin
          erd = rd_q.pop_front();
          if (f_rdata !== erd) begin
            errors++;
            $display("FAIL fetch_data t=%0t: got %h expected %h", $time, f_rdata, erd);
          end
          last_rd = erd;
        end
      end else if (f_rvalid !== 1'b0 || f_rdata !== last_rd) begin
        errors++;
        $display("FAIL rdata_hold t=%0t: got rvalid=%b rdata=%h expected rvalid=0 rdata=%h",
                 $time, f_rvalid, f_rdata, last_rd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both requests high: no grants, no memory activity.
    step(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'h10, 32'h55, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'h10, 32'h55, 1'b0, 1'b0, 1'b0, 32'h0);
    idle();

    // Single fetch of word 2.
    step(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hA000_0002);
    // Single loader write to word 4.
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'h0);
    idle();

    // Contention: four fetches, forced loader write, then fetch again.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 32'h20 + 32'(4*i), 1'b1, 1'b0, 32'hA0, 32'h1111_1111,
           1'b1, 1'b0, 1'b1, 32'hA000_0008 + 32'(i));
    step(1'b1, 1'b1, 32'h30, 1'b1, 1'b0, 32'hA0, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h30, 1'b1, 1'b0, 32'hA0, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 32'hA000_000C);
    idle();

    // Locked burst: starvation forces first write, lock holds off fetch.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 32'h40 + 32'(4*i), 1'b1, 1'b1, 32'hA4, 32'h2222_2222,
           1'b1, 1'b0, 1'b1, 32'hA000_0010 + 32'(i));
    for (int j = 0; j < 3; j++)
      step(1'b1, 1'b1, 32'h50, 1'b1, 1'b1, 32'hA4 + 32'(4*j),
           32'h2222_2222 + 32'h1111_1111 * 32'(j), 1'b0, 1'b1, 1'b0, 32'h0);
    // Lock dropped with both requesting: fetch wins immediately.
    step(1'b1, 1'b1, 32'h50, 1'b1, 1'b0, 32'hB0, 32'h5555_5555, 1'b1, 1'b0, 1'b1, 32'hA000_0014);
    step(1'b1, 1'b0, 32'h50, 1'b1, 1'b0, 32'hB0, 32'h5555_5555, 1'b0, 1'b1, 1'b0, 32'h0);
    idle();

    // Write then fetch of the same word on the next cycle.
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0013);
    // Read back earlier writes back to back.
    step(1'b1, 1'b1, 32'hA8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h3333_3333);
    step(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 32'hB0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h5555_5555);
    idle();

    // Fetch granted just before reset: its response must be discarded.
    step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle();
    idle();
    step(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hA000_0001);
    idle();
    idle();

    @(negedge clk);
    #1;
    checks++;
    if (cyc_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d cycle and %0d fetch entries pending expected 0 and 0",
               cyc_q.size(), rd_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_imem_arbiter
`default_nettype wire
